menu_connect_ctrl: RTL and testbench

- Upstream control stage for the menu pixel generator.
- Turns mouse position and left button into registered button hover flags, click events and a start pulse.
- Runs the two-board connect handshake that drives send_connect/receive_connect, which the pixel generator renders as button colours.
- Sits between the mouse/PMOD interface logic and the menu pixel generator; also reports game-start to the top-level FSM.

---
 rtl/menu_pkg.sv | 38 +++
 rtl/sync_2ff.sv | 26 ++
 rtl/menu_connect_ctrl.sv | 177 +++++++++++++++++
 tb/tb_menu_connect_ctrl.sv | 322 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/menu_pkg.sv
// Shared menu definitions: button rectangles, connect FSM states and armed-button codes.
// Also used by the menu pixel generator, which splits its vertical counter at BTN_V_SPLIT.
package menu_pkg;

  localparam int BTN_START_X0 = 240;
  localparam int BTN_START_X1 = 400;
  localparam int BTN_START_Y0 = 230;
  localparam int BTN_START_Y1 = 290;
  localparam int BTN_CONN_X0  = 240;
  localparam int BTN_CONN_X1  = 400;
  localparam int BTN_CONN_Y0  = 330;
  localparam int BTN_CONN_Y1  = 390;
  localparam int BTN_V_SPLIT  = 310;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    SENDING   = 2'd1,
    CONNECTED = 2'd2
  } conn_state_e;

  typedef enum logic [1:0] {
    ARM_NONE  = 2'd0,
    ARM_START = 2'd1,
    ARM_CONN  = 2'd2
  } armed_btn_e;

  // Half-open rectangle test: left/top edges inclusive, right/bottom edges exclusive.
  function automatic logic inRect(input logic [9:0] x, input logic [9:0] y,
                                  input int x0, input int x1,
                                  input int y0, input int y1);
    int xi;
    int yi;
    xi = int'(x);
    yi = int'(y);
    return (xi >= x0) && (xi < x1) && (yi >= y0) && (yi < y1);
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Generic two-flop synchronizer for asynchronous level inputs.
module sync_2ff #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] meta_q;
  logic [WIDTH-1:0] sync_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= '0;
      sync_q <= '0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/menu_connect_ctrl.sv
// Menu control stage: button hover/click detection, two-board connect handshake
// and start signalling towards the peer board and the top-level game FSM.
module menu_connect_ctrl
  import menu_pkg::*;
#(
  parameter int START_X0 = BTN_START_X0,
  parameter int START_X1 = BTN_START_X1,
  parameter int START_Y0 = BTN_START_Y0,
  parameter int START_Y1 = BTN_START_Y1,
  parameter int CONN_X0  = BTN_CONN_X0,
  parameter int CONN_X1  = BTN_CONN_X1,
  parameter int CONN_Y0  = BTN_CONN_Y0,
  parameter int CONN_Y1  = BTN_CONN_Y1,
  parameter int TIMEOUT  = 100_000_000,
  parameter int STRETCH  = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [9:0] mouse_x,
  input  logic [9:0] mouse_y,
  input  logic       MOUSE_LEFT,
  input  logic       peer_connect_in,
  input  logic       peer_start_in,
  output logic       mouse_on_start_button,
  output logic       mouse_on_connect_button,
  output logic       send_connect,
  output logic       receive_connect,
  output logic       connect_out,
  output logic       start_out,
  output logic       start_game
);

  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam int SW = $clog2(STRETCH + 1);
  localparam logic [TW-1:0] TIMEOUT_LAST = TW'(TIMEOUT - 1);
  localparam logic [SW-1:0] STRETCH_LOAD = SW'(STRETCH);

  logic onStart_d;
  logic onConn_d;
  logic onStart_q;
  logic onConn_q;
  logic leftBtn_q;
  logic pressEdge;
  logic releaseEdge;
  logic clickStart;
  logic clickConn;
  logic startSync;
  logic startSyncPrev_q;
  logic peerStartEvt;
  logic sendConnect_q;
  logic startGame_q;

  armed_btn_e     armed_q;
  conn_state_e    state_q;
  conn_state_e    state_d;
  logic [TW-1:0]  timeout_q;
  logic [TW-1:0]  timeout_d;
  logic [SW-1:0]  stretch_q;

  assign onStart_d = inRect(mouse_x, mouse_y, START_X0, START_X1, START_Y0, START_Y1);
  assign onConn_d  = inRect(mouse_x, mouse_y, CONN_X0, CONN_X1, CONN_Y0, CONN_Y1);

  assign pressEdge   =  MOUSE_LEFT && !leftBtn_q;
  assign releaseEdge = !MOUSE_LEFT &&  leftBtn_q;

  // A click needs press and release on the same button, judged from the registered hover flags.
  assign clickStart = releaseEdge && (armed_q == ARM_START) && onStart_q;
  assign clickConn  = releaseEdge && (armed_q == ARM_CONN)  && onConn_q;

  sync_2ff #(.WIDTH(1)) u_connSync (
    .clk   (clk),
    .rst_n (rst_n),
    .d_i   (peer_connect_in),
    .q_o   (receive_connect)
  );

  sync_2ff #(.WIDTH(1)) u_startSync (
    .clk   (clk),
    .rst_n (rst_n),
    .d_i   (peer_start_in),
    .q_o   (startSync)
  );

  assign peerStartEvt = startSync && !startSyncPrev_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      onStart_q       <= 1'b0;
      onConn_q        <= 1'b0;
      leftBtn_q       <= 1'b0;
      armed_q         <= ARM_NONE;
      startSyncPrev_q <= 1'b0;
    end else begin
      onStart_q       <= onStart_d;
      onConn_q        <= onConn_d;
      leftBtn_q       <= MOUSE_LEFT;
      startSyncPrev_q <= startSync;
      if (pressEdge) begin
        if (onStart_q) begin
          armed_q <= ARM_START;
        end else if (onConn_q) begin
          armed_q <= ARM_CONN;
        end else begin
          armed_q <= ARM_NONE;
        end
      end else if (releaseEdge) begin
        armed_q <= ARM_NONE;
      end
    end
  end

  // Peer acknowledge outranks a cancel click arriving in the same cycle.
  always_comb begin
    state_d   = state_q;
    timeout_d = timeout_q;
    case (state_q)
      IDLE: begin
        if (clickConn) begin
          state_d   = SENDING;
          timeout_d = '0;
        end
      end
      SENDING: begin
        if (receive_connect) begin
          state_d = CONNECTED;
        end else if (clickConn) begin
          state_d = IDLE;
        end else if (timeout_q == TIMEOUT_LAST) begin
          state_d = IDLE;
        end else if (timeout_q != '1) begin
          timeout_d = timeout_q + 1'b1;
        end
      end
      CONNECTED: begin
        if (!receive_connect) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      timeout_q     <= '0;
      sendConnect_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      timeout_q     <= timeout_d;
      sendConnect_q <= (state_d != IDLE);
    end
  end

  // Only a local start while linked is forwarded to the peer; a repeat click restarts the stretch.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      startGame_q <= 1'b0;
      stretch_q   <= '0;
    end else begin
      startGame_q <= clickStart || (peerStartEvt && (state_q == CONNECTED));
      if (clickStart && (state_q == CONNECTED)) begin
        stretch_q <= STRETCH_LOAD;
      end else if (stretch_q != '0) begin
        stretch_q <= stretch_q - 1'b1;
      end
    end
  end

  assign mouse_on_start_button   = onStart_q;
  assign mouse_on_connect_button = onConn_q;
  assign send_connect            = sendConnect_q;
  assign connect_out             = sendConnect_q;
  assign start_out               = (stretch_q != '0);
  assign start_game              = startGame_q;

endmodule

// File: tb/tb_menu_connect_ctrl.sv
// Self-checking bench for menu_connect_ctrl: directed scenarios plus randomized mouse
// and peer activity, all compared every cycle against an event-level reference model.
module tb_menu_connect_ctrl;

  localparam int TB_TIMEOUT = 20;
  localparam int TB_STRETCH = 4;
  localparam int M_IDLE = 0, M_SENDING = 1, M_CONNECTED = 2;
  localparam int A_NONE = 0, A_START = 1, A_CONN = 2;

  typedef struct {
    int x;
    int y;
    bit onStart;
    bit onConn;
  } hover_pt_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [9:0] mouseX;
  logic [9:0] mouseY;
  logic       mouseLeft;
  logic       peerConn;
  logic       peerStart;
  logic       onStartBtn;
  logic       onConnBtn;
  logic       sendConnect;
  logic       receiveConnect;
  logic       connectOut;
  logic       startOut;
  logic       startGame;

  int assertCount = 0;
  int failCount   = 0;
  int sgCount, sendCount, soCount;

  int mEdge, mState, mEnterEdge, mLastStart, mArmed;
  bit mLeftPrev, mHovStart, mHovConn;
  bit eStartGame, eStartOut, eSend, eRecv;
  bit pcHist[$];
  bit psHist[$];

  menu_connect_ctrl #(
    .TIMEOUT (TB_TIMEOUT),
    .STRETCH (TB_STRETCH)
  ) dut (
    .clk                     (clk),
    .rst_n                   (rst_n),
    .mouse_x                 (mouseX),
    .mouse_y                 (mouseY),
    .MOUSE_LEFT              (mouseLeft),
    .peer_connect_in         (peerConn),
    .peer_start_in           (peerStart),
    .mouse_on_start_button   (onStartBtn),
    .mouse_on_connect_button (onConnBtn),
    .send_connect            (sendConnect),
    .receive_connect         (receiveConnect),
    .connect_out             (connectOut),
    .start_out               (startOut),
    .start_game              (startGame)
  );

  always #5 clk = ~clk;

  function automatic bit hitStart(input int x, input int y);
    return (x >= 240) && (x < 400) && (y >= 230) && (y < 290);
  endfunction

  function automatic bit hitConn(input int x, input int y);
    return (x >= 240) && (x < 400) && (y >= 330) && (y < 390);
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    assertCount++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got %0d expected %0d at %0t", tag, actual, expected, $time);
    end
  endtask

  task automatic modelReset();
    mEdge      = 0;
    mState     = M_IDLE;
    mEnterEdge = 0;
    mLastStart = -1000;
    mArmed     = A_NONE;
    mLeftPrev  = 1'b0;
    mHovStart  = 1'b0;
    mHovConn   = 1'b0;
    eStartGame = 1'b0;
    eStartOut  = 1'b0;
    eSend      = 1'b0;
    eRecv      = 1'b0;
    pcHist     = '{1'b0, 1'b0, 1'b0};
    psHist     = '{1'b0, 1'b0, 1'b0};
  endtask

  // Reference behaviour at one rising edge, from the inputs present at that edge.
  // Peer lines are modelled as sample histories; timeout and stretch as elapsed edge counts.
  task automatic modelUpdate();
    int n;
    int oldState;
    bit rxPre, peerEvt, pressE, relE, clickS, clickC;
    if (!rst_n) begin
      modelReset();
      return;
    end
    mEdge++;
    pcHist.push_back(peerConn);
    psHist.push_back(peerStart);
    if (pcHist.size() > 6) void'(pcHist.pop_front());
    if (psHist.size() > 6) void'(psHist.pop_front());
    n       = pcHist.size();
    rxPre   = pcHist[n-3];
    peerEvt = psHist[n-3] && !psHist[n-4];
    pressE  = mouseLeft && !mLeftPrev;
    relE    = !mouseLeft && mLeftPrev;
    clickS  = relE && (mArmed == A_START) && mHovStart;
    clickC  = relE && (mArmed == A_CONN) && mHovConn;
    if (pressE) mArmed = mHovStart ? A_START : (mHovConn ? A_CONN : A_NONE);
    else if (relE) mArmed = A_NONE;
    oldState = mState;
    case (mState)
      M_IDLE: if (clickC) begin
        mState     = M_SENDING;
        mEnterEdge = mEdge;
      end
      M_SENDING: begin
        if (rxPre) mState = M_CONNECTED;
        else if (clickC) mState = M_IDLE;
        else if (mEdge - mEnterEdge == TB_TIMEOUT) mState = M_IDLE;
      end
      M_CONNECTED: if (!rxPre) mState = M_IDLE;
      default: mState = M_IDLE;
    endcase
    eStartGame = clickS || (peerEvt && (oldState == M_CONNECTED));
    if (clickS && (oldState == M_CONNECTED)) mLastStart = mEdge;
    eStartOut = (mEdge - mLastStart) < TB_STRETCH;
    mHovStart = hitStart(int'(mouseX), int'(mouseY));
    mHovConn  = hitConn(int'(mouseX), int'(mouseY));
    mLeftPrev = mouseLeft;
    eRecv     = pcHist[n-2];
    eSend     = (mState != M_IDLE);
  endtask

  task automatic tick();
    @(posedge clk);
    modelUpdate();
    @(negedge clk);
    checkOutput("hoverStart", 32'(onStartBtn), 32'(mHovStart));
    checkOutput("hoverConn", 32'(onConnBtn), 32'(mHovConn));
    checkOutput("sendConnect", 32'(sendConnect), 32'(eSend));
    checkOutput("connectOut", 32'(connectOut), 32'(eSend));
    checkOutput("receiveConnect", 32'(receiveConnect), 32'(eRecv));
    checkOutput("startOut", 32'(startOut), 32'(eStartOut));
    checkOutput("startGame", 32'(startGame), 32'(eStartGame));
    if (startGame) sgCount++;
    if (sendConnect) sendCount++;
    if (startOut) soCount++;
  endtask

  task automatic resetCounters();
    sgCount   = 0;
    sendCount = 0;
    soCount   = 0;
  endtask

  task automatic applyStimulus(input int x, input int y, input bit left,
                               input bit pc, input bit ps, input int n);
    mouseX    = 10'(x);
    mouseY    = 10'(y);
    mouseLeft = left;
    peerConn  = pc;
    peerStart = ps;
    repeat (n) tick();
  endtask

  task automatic doReset(input int n);
    rst_n = 1'b0;
    modelReset();
    repeat (n) tick();
    rst_n = 1'b1;
  endtask

  // Hover, press, release on one spot; counters cover the release edge and postTicks-1 more cycles.
  task automatic clickAt(input int x, input int y, input int postTicks);
    applyStimulus(x, y, 1'b0, peerConn, peerStart, 2);
    applyStimulus(x, y, 1'b1, peerConn, peerStart, 3);
    resetCounters();
    applyStimulus(x, y, 1'b0, peerConn, peerStart, postTicks);
  endtask

  task automatic pressMoveRelease(input int x0, input int y0, input int x1, input int y1);
    applyStimulus(x0, y0, 1'b0, peerConn, peerStart, 2);
    applyStimulus(x0, y0, 1'b1, peerConn, peerStart, 3);
    applyStimulus(x1, y1, 1'b1, peerConn, peerStart, 2);
    resetCounters();
    applyStimulus(x1, y1, 1'b0, peerConn, peerStart, 4);
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    hover_pt_t pts[12];
    int bx[4];
    int by[8];
    int x, y;
    pts[0]  = '{240, 230, 1'b1, 1'b0};
    pts[1]  = '{399, 289, 1'b1, 1'b0};
    pts[2]  = '{239, 250, 1'b0, 1'b0};
    pts[3]  = '{400, 250, 1'b0, 1'b0};
    pts[4]  = '{300, 229, 1'b0, 1'b0};
    pts[5]  = '{300, 290, 1'b0, 1'b0};
    pts[6]  = '{300, 330, 1'b0, 1'b1};
    pts[7]  = '{399, 389, 1'b0, 1'b1};
    pts[8]  = '{240, 389, 1'b0, 1'b1};
    pts[9]  = '{300, 390, 1'b0, 1'b0};
    pts[10] = '{240, 329, 1'b0, 1'b0};
    pts[11] = '{0, 0, 1'b0, 1'b0};
    bx = '{239, 240, 399, 400};
    by = '{229, 230, 289, 290, 329, 330, 389, 390};

    rst_n = 1'b0;
    mouseX = '0;
    mouseY = '0;
    mouseLeft = 1'b0;
    peerConn = 1'b0;
    peerStart = 1'b0;
    modelReset();
    resetCounters();

    $display("[TB] reset hold and release");
    applyStimulus(0, 0, 1'b0, 1'b0, 1'b0, 3);
    applyStimulus(300, 250, 1'b0, 1'b0, 1'b0, 2);
    checkOutput("hoverDuringReset", 32'(onStartBtn), 32'd0);
    rst_n = 1'b1;
    tick();
    checkOutput("hoverAfterRelease", 32'(onStartBtn), 32'd1);

    $display("[TB] start click while idle");
    clickAt(300, 250, 4);
    checkOutput("idleStartPulses", sgCount, 1);
    checkOutput("idleStartOutCycles", soCount, 0);

    $display("[TB] connect click with no peer, timeout");
    clickAt(300, 350, 30);
    checkOutput("timeoutSendCycles", sendCount, TB_TIMEOUT);

    $display("[TB] connect click with peer answer");
    clickAt(300, 350, 4);
    applyStimulus(300, 350, 1'b0, 1'b1, 1'b0, 6);
    checkOutput("linkedSend", 32'(sendConnect), 32'd1);
    checkOutput("linkedReceive", 32'(receiveConnect), 32'd1);

    $display("[TB] press and release on different buttons");
    pressMoveRelease(300, 250, 300, 350);
    checkOutput("crossStartToConnPulses", sgCount, 0);
    checkOutput("crossStartToConnSend", sendCount, 4);
    pressMoveRelease(300, 350, 300, 250);
    checkOutput("crossConnToStartPulses", sgCount, 0);
    checkOutput("crossConnToStartSend", sendCount, 4);

    $display("[TB] start click while connected");
    clickAt(300, 250, 8);
    checkOutput("linkedStartPulses", sgCount, 1);
    checkOutput("linkedStartOutCycles", soCount, TB_STRETCH);

    $display("[TB] peer start while connected");
    resetCounters();
    applyStimulus(300, 250, 1'b0, 1'b1, 1'b1, 6);
    checkOutput("peerStartLinkedPulses", sgCount, 1);
    applyStimulus(300, 250, 1'b0, 1'b1, 1'b0, 3);

    $display("[TB] link lost, then peer start while idle");
    resetCounters();
    applyStimulus(300, 250, 1'b0, 1'b0, 1'b0, 5);
    checkOutput("linkLostSendCycles", sendCount, 2);
    resetCounters();
    applyStimulus(300, 250, 1'b0, 1'b0, 1'b1, 6);
    checkOutput("peerStartIdlePulses", sgCount, 0);
    applyStimulus(300, 250, 1'b0, 1'b0, 1'b0, 3);

    $display("[TB] reset in the middle of sending");
    clickAt(300, 350, 3);
    doReset(2);
    checkOutput("sendAfterMidReset", 32'(sendConnect), 32'd0);
    tick();

    $display("[TB] rectangle boundaries");
    foreach (pts[i]) begin
      applyStimulus(pts[i].x, pts[i].y, 1'b0, 1'b0, 1'b0, 1);
      checkOutput("edgeHoverStart", 32'(onStartBtn), 32'(pts[i].onStart));
      checkOutput("edgeHoverConn", 32'(onConnBtn), 32'(pts[i].onConn));
    end

    $display("[TB] randomized activity");
    x = 300;
    y = 250;
    for (int seg = 0; seg < 3000; seg++) begin
      if ($urandom_range(0, 2) == 0) begin
        case ($urandom_range(0, 3))
          0: begin x = $urandom_range(240, 399); y = $urandom_range(230, 289); end
          1: begin x = $urandom_range(240, 399); y = $urandom_range(330, 389); end
          2: begin x = $urandom_range(0, 639); y = $urandom_range(0, 479); end
          default: begin x = bx[$urandom_range(0, 3)]; y = by[$urandom_range(0, 7)]; end
        endcase
      end
      if ($urandom_range(0, 1) == 0) mouseLeft = ~mouseLeft;
      if ($urandom_range(0, 9) == 0) peerConn = ~peerConn;
      if ($urandom_range(0, 3) == 0) peerStart = ~peerStart;
      applyStimulus(x, y, mouseLeft, peerConn, peerStart, $urandom_range(1, 4));
      if ($urandom_range(0, 299) == 0) doReset($urandom_range(1, 3));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
